// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings and the E/M/W scoreboard slot record for hazard_ctrl.
// Pure definitions; no logic, latency or flow control.
package hazard_ctrl_pkg;

  localparam logic [1:0] FWD_GRF   = 2'd0;
  localparam logic [1:0] FWD_E     = 2'd1;
  localparam logic [1:0] FWD_M     = 2'd2;
  localparam logic [1:0] FWD_W     = 2'd3;
  localparam logic [1:0] TUSE_NONE = 2'd3;

  typedef struct packed {
    logic [4:0] dst;
    logic [1:0] tnew;
  } slot_t;

  localparam slot_t SLOT_EMPTY = '{dst: 5'd0, tnew: 2'd0};

  typedef struct packed {
    logic       stall;
    logic [1:0] sel;
  } src_res_t;

  // One stage of ageing: the producer is a cycle closer to its result.
  function automatic slot_t age_slot(input slot_t s);
    slot_t r;
    r.dst  = s.dst;
    r.tnew = (s.tnew == 2'd0) ? 2'd0 : s.tnew - 2'd1;
    return r;
  endfunction

endpackage

// File: rtl/md_busy_cnt.sv
// MDU occupancy counter: loads the mult/div latency on an accepted start, counts down to idle.
// busy is registered (valid the cycle after the load); a load wins over the decrement.
module md_busy_cnt #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic is_div,
  output logic busy
);

  localparam int MAX_CYC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYC);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYC);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= is_div ? DIV_LOAD : MULT_LOAD;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// D-stage hazard unit: combinational stall/forward selects from an E/M/W {dst,tnew} scoreboard plus MDU busy.
// Outputs are same-cycle; HAZARD_FWD_EN enables forwarding, otherwise any pending writer of a source stalls.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] D_rs_adr,
  input  logic [4:0] D_rt_adr,
  input  logic [1:0] D_tuse_rs,
  input  logic [1:0] D_tuse_rt,
  input  logic [4:0] D_dst,
  input  logic [1:0] D_tnew,
  input  logic       D_md_start,
  input  logic       D_md_div,
  input  logic       D_md_use,
  output logic       stall,
  output logic [1:0] fwd_rs_sel,
  output logic [1:0] fwd_rt_sel,
  output logic       md_busy
);

  slot_t    slot_e, slot_m, slot_w;
  src_res_t rs_res, rt_res;
  logic     data_stall, md_stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_e <= SLOT_EMPTY;
      slot_m <= SLOT_EMPTY;
      slot_w <= SLOT_EMPTY;
    end else begin
      slot_e <= stall ? SLOT_EMPTY : '{dst: D_dst, tnew: D_tnew};
      slot_m <= age_slot(slot_e);
      slot_w <= age_slot(slot_m);
    end
  end

`ifdef HAZARD_FWD_EN
  // Only the youngest writer of a register is authoritative; older slots are shadowed.
  function automatic src_res_t eval_src(input logic [4:0] adr, input logic [1:0] tuse,
                                        input slot_t e, input slot_t m, input slot_t w);
    src_res_t r;
    slot_t    near;
    logic [1:0] code;
    logic     hit;
    r    = '0;
    near = SLOT_EMPTY;
    code = FWD_GRF;
    hit  = 1'b0;
    if (tuse != TUSE_NONE && adr != 5'd0) begin
      if (e.dst == adr) begin
        hit = 1'b1; near = e; code = FWD_E;
      end else if (m.dst == adr) begin
        hit = 1'b1; near = m; code = FWD_M;
      end else if (w.dst == adr) begin
        hit = 1'b1; near = w; code = FWD_W;
      end
    end
    r.stall = hit && (near.tnew > tuse);
    r.sel   = (hit && near.tnew == 2'd0) ? code : FWD_GRF;
    return r;
  endfunction

  always_comb begin
    rs_res = eval_src(D_rs_adr, D_tuse_rs, slot_e, slot_m, slot_w);
    rt_res = eval_src(D_rt_adr, D_tuse_rt, slot_e, slot_m, slot_w);
  end
`else
  function automatic logic hit_any(input logic [4:0] adr, input logic [1:0] tuse,
                                   input logic [4:0] e, input logic [4:0] m, input logic [4:0] w);
    return (tuse != TUSE_NONE) && (adr != 5'd0) && (adr == e || adr == m || adr == w);
  endfunction

  always_comb begin
    rs_res       = '0;
    rt_res       = '0;
    rs_res.stall = hit_any(D_rs_adr, D_tuse_rs, slot_e.dst, slot_m.dst, slot_w.dst);
    rt_res.stall = hit_any(D_rt_adr, D_tuse_rt, slot_e.dst, slot_m.dst, slot_w.dst);
  end

  // W-slot age only matters when results can be forwarded.
  logic unused_w_tnew;
  assign unused_w_tnew = ^slot_w.tnew;
`endif

  assign data_stall = rs_res.stall | rt_res.stall;
  assign md_stall   = (D_md_start | D_md_use) & md_busy;
  assign stall      = data_stall | md_stall;
  assign fwd_rs_sel = rs_res.sel;
  assign fwd_rt_sel = rt_res.sel;

  md_busy_cnt #(
    .MULT_CYC (MULT_CYC),
    .DIV_CYC  (DIV_CYC)
  ) u_md_busy_cnt (
    .clk    (clk),
    .reset  (reset),
    .start  (D_md_start & ~stall),
    .is_div (D_md_div),
    .busy   (md_busy)
  );

endmodule
